// File: rtl/posit_pkg.sv
// Shared posit constants: default format, derived scale width, saturation scales and special codes.
package posit_pkg;

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 4;

    function automatic int scale_width(input int n, input int es);
        return $clog2((n - 2) * (2 ** (es + 2))) + 1;
    endfunction

    function automatic int max_scale(input int n, input int es);
        return (n - 2) * (2 ** es);
    endfunction

    localparam int POSIT_SW           = scale_width(POSIT_N, POSIT_ES);
    localparam int POSIT_MAXPOS_SCALE = max_scale(POSIT_N, POSIT_ES);
    localparam int POSIT_MINPOS_SCALE = -POSIT_MAXPOS_SCALE;

    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;

endpackage

// File: rtl/posit_encoder_pipe_round.sv
// Round-to-nearest-even of an unsigned posit magnitude with guard/sticky, saturating at maxpos.
module posit_round #(
    parameter int M = 7
) (
    input  logic [M-1:0] mag,
    input  logic         guard,
    input  logic         sticky,
    output logic [M-1:0] rounded
);

    function automatic logic [M-1:0] rne(input logic [M-1:0] m, input logic g, input logic s);
        logic [M-1:0] r;
        r = m;
        // All-ones is maxpos; incrementing it would wrap into the NaR pattern.
        if (g && (s || m[0]) && !(&m)) r = m + 1'b1;
        return r;
    endfunction

    assign rounded = rne(mag, guard, sticky);

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage posit encoder: stage 1 builds regime/exponent/fraction bits, stage 2 rounds, signs and registers.
module posit_encoder_pipe
    import posit_pkg::*;
#(
    parameter int  N  = POSIT_N,
    parameter int  ES = POSIT_ES,
    parameter int  FW = 2 * N,
    localparam int SW = scale_width(N, ES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [SW-1:0] in_scale,
    input  logic [FW-1:0]        in_frac,
    input  logic                 in_zero,
    input  logic                 in_nar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit
);

    localparam int                   T        = N + ES + FW;
    localparam logic signed [SW-1:0] MAX_S    = SW'(max_scale(N, ES));
    localparam logic signed [SW-1:0] MIN_S    = -MAX_S;
    localparam logic [N-1:0]         NAR_CODE = {1'b1, {(N-1){1'b0}}};

    logic signed [SW-1:0] scale_c;
    logic signed [SW-1:0] k_c;
    logic [SW-1:0]        run_c;
    logic [SW-1:0]        shamt_c;
    logic                 fill_c;
    logic [T-1:0]         full_c;

    logic                 vld_p1;
    logic                 sign_p1;
    logic                 zero_p1;
    logic                 nar_p1;
    logic [N-2:0]         mag_p1;
    logic                 guard_p1;
    logic                 sticky_p1;

    logic [N-2:0]         rnd_c;
    logic [N-1:0]         posit_c;
    logic                 vld_p2;
    logic [N-1:0]         posit_p2;

    logic                 load_p1;
    logic                 load_p2;

    assign load_p2   = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || load_p2;
    assign load_p1   = in_valid && in_ready;
    assign out_valid = vld_p2;
    assign out_posit = posit_p2;

    // Stage 1: clamp, regime run + exponent + fraction, keep N-1 bits with guard and sticky.
    always_comb begin
        scale_c = in_scale;
        if (in_scale > MAX_S) begin
            scale_c = MAX_S;
        end else if (in_scale < MIN_S) begin
            scale_c = MIN_S;
        end
        k_c     = scale_c >>> ES;
        fill_c  = !k_c[SW-1];
        run_c   = k_c[SW-1] ? SW'(-k_c) : SW'(k_c + 1);
        // Surplus run bits sit above the kept window and are shifted out.
        shamt_c = SW'(N - 1) - run_c;
        full_c  = {{(N-1){fill_c}}, !fill_c, scale_c[ES-1:0], in_frac} << shamt_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1) begin
            sign_p1   <= in_sign;
            zero_p1   <= in_zero;
            nar_p1    <= in_nar;
            mag_p1    <= full_c[T-1 -: N-1];
            guard_p1  <= full_c[T-N];
            sticky_p1 <= |full_c[T-N-1:0];
        end
    end

    // Stage 2: round magnitude, apply sign and special codes, register output.
    posit_round #(
        .M (N - 1)
    ) u_round (
        .mag     (mag_p1),
        .guard   (guard_p1),
        .sticky  (sticky_p1),
        .rounded (rnd_c)
    );

    always_comb begin
        posit_c = sign_p1 ? -{1'b0, rnd_c} : {1'b0, rnd_c};
        if (zero_p1) posit_c = '0;
        if (nar_p1)  posit_c = NAR_CODE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            posit_p2 <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) posit_p2 <= posit_c;
        end
    end

endmodule

// File: doc/posit_encoder_pipe.md
POSIT_ENCODER_PIPE -- requirements
Module: posit_encoder_pipe

Interface
REQ-001 Parameter N, default 8: posit word width.
REQ-002 Parameter ES, default 4: exponent field width.
REQ-003 Parameter FW, default 2*N: width of the input fraction (hidden bit excluded).
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 in_valid  input  1: input operand present.
REQ-007 in_ready  output  1: stage 1 can accept.
REQ-008 in_sign  input  1: 1 = negative value.
REQ-009 in_scale  input  SW (signed): total power-of-two exponent, k*2^ES+e; SW = $clog2((N-2)*2^(ES+2))+1 (10 for defaults).
REQ-010 in_frac  input  FW: fraction bits after the binary point, MSB first.
REQ-011 in_zero  input  1: value is exactly zero.
REQ-012 in_nar  input  1: value is Not-a-Real.
REQ-013 out_valid  output  1: out_posit valid.
REQ-014 out_ready  input  1: downstream accepts.
REQ-015 out_posit  output  N: encoded posit, two's complement for negatives.

Function
REQ-016 Transfer on a port SHALL occur when valid and ready are both high on a rising edge.
REQ-017 Two-stage pipeline, latency 2 cycles from input transfer to out_valid with no stall; throughput 1 per cycle.
REQ-018 Stage 1: clamp scale, split into k = floor(scale/2^ES) and e = scale mod 2^ES, build regime run (k>=0: k+1 ones then 0; k<0: -k zeros then 1), then e, then frac; keep N-1 bits plus guard and sticky (OR of remainder).
REQ-019 Stage 2: round to nearest, ties to even on the N-1 magnitude bits; two's-complement negate when sign set; register out_posit.
REQ-020 Scale > (N-2)*2^ES SHALL produce maxpos (0x7F for defaults, sign applied); rounding SHALL never overflow maxpos into NaR.
REQ-021 Scale < -(N-2)*2^ES SHALL produce minpos (0x01); a non-zero value SHALL never encode to zero.
REQ-022 in_nar SHALL produce 0x80 (1 followed by zeros), overriding all other inputs including in_zero.
REQ-023 in_zero (without in_nar) SHALL produce 0x00 regardless of sign, scale, frac.
REQ-024 Each stage holds its data while its successor is full and stalled; a stage SHALL load when empty or when its content moves on the same edge.
REQ-025 in_ready SHALL equal !stage1_full || stage1_moves (combinational from out_ready allowed); no bubbles under continuous out_ready.
REQ-026 out_valid and out_posit SHALL remain stable while out_valid && !out_ready.

Reset
REQ-027 On rst_n low, both stage valid flags clear immediately; out_valid = 0, out_posit = 0, in_ready = 1 after reset release.
REQ-028 Reset mid-operation SHALL discard in-flight data; no output transfer occurs for it.

Structure
REQ-029 Package posit_pkg holds N, ES defaults, derived widths SW, maxpos/minpos scale constants, and NaR/zero codes.
REQ-030 One sub-module, posit_round: combinational RNE of N-1 bits plus guard/sticky with saturation at maxpos, instantiated in stage 2.

Verification
REQ-031 scale 0, frac 0, sign 0 -> 0x40; sign 1 -> 0xC0; scale 16 -> 0x60; scale 1 -> 0x42.
REQ-032 Rounding, scale 0: frac 0.1b -> 0x41; 0.01b -> 0x40 (tie to even); 0.11b -> 0x42 (tie to even).
REQ-033 Saturation: scale 96 -> 0x7F; scale 200 -> 0x7F; scale -200 -> 0x01; scale -200 sign 1 -> 0xFF.
REQ-034 Specials: in_nar=1 -> 0x80; in_zero=1, sign 1 -> 0x00; both set -> 0x80.
REQ-035 Backpressure: 10 back-to-back inputs, out_ready toggled randomly -> all 10 outputs in order, none lost or duplicated, out_posit stable while stalled.
REQ-036 Reset asserted with 2 items in flight -> out_valid falls immediately, no output after release, first new input appears 2 cycles after its transfer.
